// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: state encoding and
// the address-width helper used to size address ports from DEPTH.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Number of address bits needed to index 'depth' entries (depth >= 2).
  function automatic int f_aw(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Control side of the register file: CLEAR/RUN state, clear counter,
// ready / wr_drop flags and the single write port mux (clear vs user write).
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = f_aw(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr_req,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_run,
  output logic            o_ready,
  output logic            o_wr_drop,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_waddr,
  output logic [XLEN-1:0] o_mem_wdata
);

  state_e          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_wr_drop;
  logic            w_last;
  logic            w_user_wr;

  assign w_last    = (r_cnt == AW'(DEPTH - 1));
  // Writes to the hard-wired zero register are discarded without a drop pulse.
  assign w_user_wr = i_we && !((ZERO_REG != 0) && (i_waddr == '0));

  // State, clear counter and registered status flags; clr_req always restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_wr_drop <= i_we;
          if (i_clr_req) begin
            r_cnt <= '0;
          end else if (w_last) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        ST_RUN: begin
          if (i_clr_req) begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Write port mux: the clear sweep owns the port while clearing.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_waddr = i_waddr;
    o_mem_wdata = i_wdata;
    if (r_state == ST_CLEAR) begin
      o_mem_we    = 1'b1;
      o_mem_waddr = r_cnt;
      o_mem_wdata = '0;
    end else begin
      o_mem_we    = w_user_wr;
    end
  end

  assign o_run     = (r_state == ST_RUN);
  assign o_ready   = r_ready;
  assign o_wr_drop = r_wr_drop;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hard-wired zero register, optional
// write-to-read bypass and a sequential clear engine gating issue via ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = f_aw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic                  ready,
  output logic                  wr_drop
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic            w_run;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [XLEN-1:0] w_mem_wdata;

  regfile_clear_seq #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr_req   (clr_req),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_run       (w_run),
    .o_ready     (ready),
    .o_wr_drop   (wr_drop),
    .o_mem_we    (w_mem_we),
    .o_mem_waddr (w_mem_waddr),
    .o_mem_wdata (w_mem_wdata)
  );

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_rd;

    assign w_addr = raddr[k*AW +: AW];

    // Per-port read mux: CLEAR forces zero, then zero register, bypass, array.
    always_comb begin
      w_rd = r_mem[w_addr];
      if (!w_run) begin
        w_rd = '0;
      end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && we && (w_addr == waddr)) begin
        w_rd = wdata;
      end
    end

    assign rdata[k*XLEN +: XLEN] = w_rd;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the RV32I datapath. It replaces the single-write, two-read array in the decode stage and adds:
- configurable width, depth and read-port count;
- a hard-wired zero register;
- same-cycle write-to-read bypass;
- a sequential clear engine, so every entry holds zero after reset or after a flush request.

The hazard unit and the ID stage use the `ready` output to stall issue while the array is being cleared.

## Interface
- `XLEN`, 32: data word width in bits.
- `DEPTH`, 32: number of registers; must be a power of two and at least 2. `AW = log2(DEPTH)`.
- `NREAD`, 2: number of independent read ports (1–4).
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and writes to it are discarded.
- `BYPASS`, 1: when 1, a read of the address being written in the same cycle returns the write data.
- `clk` — in, 1: single clock. All state updates on the rising edge.
- `rst_n` — in, 1: asynchronous, active-low reset.
- `clr_req` — in, 1: single-cycle request to clear all entries.
- `we` — in, 1: write enable.
- `waddr` — in, AW: write address.
- `wdata` — in, XLEN: write data.
- `raddr` — in, NREAD*AW: packed read addresses; port k occupies bits `[k*AW +: AW]`.
- `rdata` — out, NREAD*XLEN: packed read data; port k occupies bits `[k*XLEN +: XLEN]`.
- `ready` — out, 1: array is valid and accepting writes.
- `wr_drop` — out, 1: one-cycle pulse when a write was discarded because `ready` was low.

## Operation
- State machine with two states, CLEAR and RUN.
- **Reset:** `rst_n` low asynchronously forces state CLEAR, clear counter 0, `ready` 0, `wr_drop` 0.
- **CLEAR state:**
  - Each rising edge writes 0 to entry `cnt`, then `cnt` increments.
  - On the edge where `cnt == DEPTH-1`, the state becomes RUN.
  - All DEPTH entries are cleared, including entry 0.
- **RUN state:** on each rising edge with `we` high, `mem[waddr]` is written with `wdata`.
  - Exception: `ZERO_REG` is 1 and `waddr` is 0, in which case the write is silently discarded; `wr_drop` does not pulse.
- **`clr_req` in RUN:** the next state is CLEAR with `cnt` set to 0. A write in that same cycle is still performed; it is overwritten later by the clear.
- **`clr_req` in CLEAR:** `cnt` restarts at 0.
- **`we` while not in RUN:** the write is ignored, and `wr_drop` is high for the following cycle.
- **Reads:** combinational from `raddr`, evaluated per port:
  - If state is CLEAR, the port returns 0.
  - Otherwise, if `ZERO_REG` is 1 and the address is 0, it returns 0.
  - Otherwise, if `BYPASS` is 1 and `we` is high and the address equals `waddr`, it returns `wdata`. This bypass is subject to the same zero-register rule.
  - Otherwise it returns `mem[addr]`.
- Read ports are independent; any number of ports may read the same address.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- **Reset values:** `ready` 0, `wr_drop` 0, `rdata` all zero (forced by the CLEAR state).
- **Reset recovery:** `ready` rises after exactly DEPTH rising edges following `rst_n` deassertion.
- **Write latency:**
  - 0 cycles with the bypass enabled.
  - Without the bypass, data is visible on `rdata` after the write edge, i.e. 1 cycle.
- **Flush:** `ready` falls on the edge after `clr_req` is sampled, and rises DEPTH edges after that.
- **Reset during CLEAR:** `rst_n` asserted mid-clear aborts the clear; clearing restarts from entry 0 after release.
- **Outputs:** `ready` and `wr_drop` are registered; `rdata` is combinational.

## Structure
- Shared package `regfile_pkg`:
  - state encoding constants `ST_CLEAR = 1'b0` and `ST_RUN = 1'b1`;
  - a helper function for `AW`.
- One sub-module, `regfile_clear_seq`, holding the state register, the clear counter, the `ready` and `wr_drop` generation, and the write-port mux (clear versus user write).
- The array and the NREAD read muxes, generated with a generate loop, live in the top module.

## Test plan
- **Reset recovery:** release `rst_n` with `DEPTH` = 32 → `ready` is low for 32 edges, then high; every `rdata` is 0 throughout.
- **Write then read:** write `0xDEADBEEF` to x5, then read x5 on all ports → all ports return `0xDEADBEEF`.
- **Bypass:** drive `we` with address x7, data `0x12345678`, and `raddr` x7 in the same cycle → `rdata` equals `0x12345678` combinationally. With `BYPASS` = 0 the old value is returned until after the edge.
- **Zero register:** write `0xFFFFFFFF` to x0 → reads of x0 return 0 and `wr_drop` stays low.
- **Flush:**
  - Fill x1–x31, then pulse `clr_req` → `ready` drops the next cycle and every read returns 0.
  - A write during CLEAR pulses `wr_drop` and is lost.
  - After 32 edges `ready` returns and all entries read 0.
- **Reset mid-clear:** assert `rst_n` low at `cnt` = 10, then release → a full 32-cycle clear occurs before `ready` rises.
